// File: rtl/his_peak_extract_pkg.sv
// Shared defaults for the time-of-flight peak extractor.
// Defaults match the histogram builder's bin width, count width, pixels per RAM and hits per pixel.
// Also provides a counter-width helper that stays at least 1 bit wide.
package his_peak_extract_pkg;

  localparam int NB_DEF        = 8;    // bin address width
  localparam int CW_DEF        = 16;   // count width
  localparam int PIXEL_NUM_DEF = 200;  // pixels per RAM
  localparam int DATA_NUM_DEF  = 2;    // hits per pixel before the pixel index advances
  localparam int MIN_CNT_DEF   = 4;    // minimum peak count for a valid hit

  // Width of a counter over 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/his_peak_extract_if.sv
// Bundles for the peak extractor: hit-update input stream and peak-record output stream.
// hit stream: no handshake, one update per hit_vld cycle; acq_done is a single-cycle frame marker.
// pk stream: valid/ready, and the master holds a record stable until pk_vld & pk_rdy.
interface his_peak_extract_hit_if
  import his_peak_extract_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int CW = CW_DEF
) ();
  logic          hit_vld;   // update valid
  logic [NB-1:0] hit_addr;  // bin address of the update
  logic [CW-1:0] hit_cnt;   // bin count after the increment
  logic          acq_done;  // frame complete pulse

  modport master (output hit_vld, hit_addr, hit_cnt, acq_done);
  modport slave  (input  hit_vld, hit_addr, hit_cnt, acq_done);
endinterface

interface his_peak_extract_pk_if
  import his_peak_extract_pkg::*;
#(
  parameter int NB        = NB_DEF,
  parameter int CW        = CW_DEF,
  parameter int PIXEL_NUM = PIXEL_NUM_DEF
) ();
  localparam int PW = $clog2(PIXEL_NUM);

  logic          pk_vld;    // record valid
  logic          pk_rdy;    // downstream ready
  logic [PW-1:0] pk_pixel;  // pixel index
  logic [NB-1:0] pk_bin;    // bin of the maximum count
  logic [CW-1:0] pk_cnt;    // maximum count
  logic          pk_hit;    // pk_cnt >= MIN_CNT
  logic          pk_last;   // last pixel of the frame

  modport master (output pk_vld, pk_pixel, pk_bin, pk_cnt, pk_hit, pk_last, input pk_rdy);
  modport slave  (input  pk_vld, pk_pixel, pk_bin, pk_cnt, pk_hit, pk_last, output pk_rdy);
endinterface

// File: rtl/his_peak_extract_peak_bank.sv
// One peak bank: PIXEL_NUM entries of {cnt, bin}; port A compare/update, port B read plus clear.
// Port A updates at the next edge; port B read is combinational, the caller registers it.
// No backpressure; port B clear wins over a port A update to the same entry.
// Ports: clk, res (async active-low); a_vld/a_pix/a_addr/a_cnt update request;
//        b_rd_pix -> b_cnt/b_bin read; b_clr_vld/b_clr_pix zero one entry.
module his_peak_extract_peak_bank
  import his_peak_extract_pkg::*;
#(
  parameter int NB        = NB_DEF,
  parameter int CW        = CW_DEF,
  parameter int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int PW        = $clog2(PIXEL_NUM_DEF)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          a_vld,
  input  logic [PW-1:0] a_pix,
  input  logic [NB-1:0] a_addr,
  input  logic [CW-1:0] a_cnt,
  input  logic [PW-1:0] b_rd_pix,
  output logic [CW-1:0] b_cnt,
  output logic [NB-1:0] b_bin,
  input  logic          b_clr_vld,
  input  logic [PW-1:0] b_clr_pix
);

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [NB-1:0] bin;
  } ent_t;

  ent_t ents [PIXEL_NUM];
  logic a_upd;

  // Entries are flops and the compare reads them combinationally, so a hit on
  // the entry written at the previous edge already sees the new value: this is
  // the same-entry bypass, with no separate forwarding path to go stale after a clear.
  // Strict greater-than keeps the earlier bin on ties.
  assign a_upd = a_vld && (a_cnt > ents[a_pix].cnt);

  for (genvar i = 0; i < PIXEL_NUM; i++) begin : g_ent
    ent_t q;
    always_ff @(posedge clk or negedge res) begin
      if (!res) begin
        q <= '0;
      end else if (b_clr_vld && (b_clr_pix == PW'(i))) begin
        q <= '0;
      end else if (a_upd && (a_pix == PW'(i))) begin
        q <= '{cnt: a_cnt, bin: a_addr};
      end
    end
    assign ents[i] = q;
  end

  assign b_cnt = ents[b_rd_pix].cnt;
  assign b_bin = ents[b_rd_pix].bin;

endmodule

// File: rtl/his_peak_extract.sv
// Tracks the per-pixel ToF peak from the bin-update stream and drains one record per pixel per frame.
// acq_done at cycle t gives the first pk_vld at t+2; each record then takes at least 2 cycles.
// pk_* is held until pk_vld & pk_rdy; an acq_done during a drain is discarded and flagged in ovf_err.
// Ports: clk, res (async active-low); hit (slave: hit_vld/hit_addr/hit_cnt/acq_done);
//        pk (master: pk_vld/pk_rdy/pk_pixel/pk_bin/pk_cnt/pk_hit/pk_last); ovf_err sticky overlap flag.
module his_peak_extract
  import his_peak_extract_pkg::*;
#(
  parameter int NB        = NB_DEF,
  parameter int CW        = CW_DEF,
  parameter int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int DATA_NUM  = DATA_NUM_DEF,
  parameter int MIN_CNT   = MIN_CNT_DEF
) (
  input  logic                  clk,
  input  logic                  res,
  his_peak_extract_hit_if.slave hit,
  his_peak_extract_pk_if.master pk,
  output logic                  ovf_err
);

  localparam int PW  = $clog2(PIXEL_NUM);
  localparam int ICW = cnt_w(DATA_NUM);
  localparam logic [PW-1:0]  LAST_PIX = PW'(PIXEL_NUM - 1);
  localparam logic [ICW-1:0] LAST_IN  = ICW'(DATA_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_OUT} st_t;

  st_t            st;
  logic [PW-1:0]  pix;        // accumulation entry
  logic [ICW-1:0] icnt;       // hits seen on the current entry
  logic [PW-1:0]  rd_pix;     // drain entry
  logic [PW-1:0]  sweep_pix;  // discard-sweep entry
  logic           wr_bank;
  logic           rd_bank;
  logic           sweep_act;

  logic           hit_take;
  logic           acq_ovf;
  logic           ack;
  logic [1:0]     a_vld;
  logic [1:0]     clr_vld;
  logic [PW-1:0]  clr_pix [2];
  logic [CW-1:0]  b_cnt   [2];
  logic [NB-1:0]  b_bin   [2];
  logic [CW-1:0]  rd_cnt;
  logic [NB-1:0]  rd_bin;

  // Hits are dropped while the write bank is being swept clean.
  assign hit_take = hit.hit_vld && !sweep_act;
  // A frame that ends while the other bank is still draining (or while a previous
  // discard sweep is still running) has nowhere to go and is discarded.
  assign acq_ovf  = hit.acq_done && ((st != S_IDLE) || sweep_act);
  assign ack      = (st == S_OUT) && pk.pk_rdy;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    // Clear-on-ack targets rd_bank and the sweep targets wr_bank; these differ
    // whenever both are active, so each bank sees at most one clear source.
    assign a_vld[k]   = hit_take && (wr_bank == 1'(k));
    assign clr_vld[k] = (ack && (rd_bank == 1'(k))) || (sweep_act && (wr_bank == 1'(k)));
    assign clr_pix[k] = (sweep_act && (wr_bank == 1'(k))) ? sweep_pix : rd_pix;

    his_peak_extract_peak_bank #(
      .NB        (NB),
      .CW        (CW),
      .PIXEL_NUM (PIXEL_NUM),
      .PW        (PW)
    ) u_bank (
      .clk       (clk),
      .res       (res),
      .a_vld     (a_vld[k]),
      .a_pix     (pix),
      .a_addr    (hit.hit_addr),
      .a_cnt     (hit.hit_cnt),
      .b_rd_pix  (rd_pix),
      .b_cnt     (b_cnt[k]),
      .b_bin     (b_bin[k]),
      .b_clr_vld (clr_vld[k]),
      .b_clr_pix (clr_pix[k])
    );
  end

  assign rd_cnt = rd_bank ? b_cnt[1] : b_cnt[0];
  assign rd_bin = rd_bank ? b_bin[1] : b_bin[0];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st          <= S_IDLE;
      pix         <= '0;
      icnt        <= '0;
      rd_pix      <= '0;
      sweep_pix   <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      sweep_act   <= 1'b0;
      ovf_err     <= 1'b0;
      pk.pk_vld   <= 1'b0;
      pk.pk_pixel <= '0;
      pk.pk_bin   <= '0;
      pk.pk_cnt   <= '0;
      pk.pk_hit   <= 1'b0;
      pk.pk_last  <= 1'b0;
    end else begin
      // Input position. A hit in the acq_done cycle was already applied to the
      // ending frame by the bank; the next frame always starts at entry 0.
      if (hit.acq_done) begin
        pix  <= '0;
        icnt <= '0;
      end else if (hit_take) begin
        if (icnt == LAST_IN) begin
          icnt <= '0;
          pix  <= (pix == LAST_PIX) ? '0 : pix + PW'(1);
        end else begin
          icnt <= icnt + ICW'(1);
        end
      end

      // Discarded frame: wipe the write bank one entry per cycle.
      if (acq_ovf) begin
        ovf_err   <= 1'b1;
        sweep_act <= 1'b1;
        sweep_pix <= '0;
      end else if (sweep_act) begin
        sweep_pix <= sweep_pix + PW'(1);
        if (sweep_pix == LAST_PIX) begin
          sweep_act <= 1'b0;
        end
      end

      case (st)
        S_IDLE: begin
          if (hit.acq_done && !sweep_act) begin
            wr_bank <= ~wr_bank;
            rd_bank <= wr_bank;
            rd_pix  <= '0;
            st      <= S_RD;
          end
        end
        S_RD: begin
          pk.pk_vld   <= 1'b1;
          pk.pk_pixel <= rd_pix;
          pk.pk_bin   <= rd_bin;
          pk.pk_cnt   <= rd_cnt;
          pk.pk_hit   <= (rd_cnt >= CW'(MIN_CNT));
          pk.pk_last  <= (rd_pix == LAST_PIX);
          st          <= S_OUT;
        end
        S_OUT: begin
          if (pk.pk_rdy) begin
            pk.pk_vld <= 1'b0;
            if (pk.pk_last) begin
              st <= S_IDLE;
            end else begin
              rd_pix <= rd_pix + PW'(1);
              st     <= S_RD;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_his_peak_extract.sv
// Directed bench for his_peak_extract: hand-set hit sequences, a per-frame peak model and a record checker.
// Records are checked as they are accepted; stalled records must hold their value.
// Covers reset, ties, same-entry updates, full frames, backpressure, overlap and reset mid-drain.
module tb_his_peak_extract;
  import his_peak_extract_pkg::*;

  localparam int NB = NB_DEF;
  localparam int CW = CW_DEF;
  localparam int PN = PIXEL_NUM_DEF;
  localparam int DN = DATA_NUM_DEF;
  localparam int MC = MIN_CNT_DEF;
  localparam int PW = $clog2(PN);

  logic clk = 1'b0;
  logic res = 1'b0;
  logic ovf_err;

  always #5 clk = ~clk;

  his_peak_extract_hit_if #(.NB(NB), .CW(CW)) hit_if ();
  his_peak_extract_pk_if  #(.NB(NB), .CW(CW), .PIXEL_NUM(PN)) pk_if ();

  his_peak_extract dut (
    .clk     (clk),
    .res     (res),
    .hit     (hit_if),
    .pk      (pk_if),
    .ovf_err (ovf_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int rec_n = 0;

  // Model: f_* accumulates the open frame, d_* holds the frame being drained.
  logic [CW-1:0] f_cnt [PN];
  logic [NB-1:0] f_bin [PN];
  logic [CW-1:0] d_cnt [PN];
  logic [NB-1:0] d_bin [PN];
  int            m_pix;
  int            m_icnt;
  logic [24:0]   cap [PN];  // {bin, cnt, hit} of each accepted record

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear_frame();
    for (int i = 0; i < PN; i++) begin
      f_cnt[i] = '0;
      f_bin[i] = '0;
    end
    m_pix  = 0;
    m_icnt = 0;
  endtask

  task automatic model_reset();
    model_clear_frame();
    for (int i = 0; i < PN; i++) begin
      d_cnt[i] = '0;
      d_bin[i] = '0;
    end
  endtask

  task automatic model_hit(input logic [NB-1:0] a, input logic [CW-1:0] c);
    if (c > f_cnt[m_pix]) begin
      f_cnt[m_pix] = c;
      f_bin[m_pix] = a;
    end
    m_icnt++;
    if (m_icnt == DN) begin
      m_icnt = 0;
      m_pix  = (m_pix + 1) % PN;
    end
  endtask

  task automatic model_swap();
    for (int i = 0; i < PN; i++) begin
      d_cnt[i] = f_cnt[i];
      d_bin[i] = f_bin[i];
    end
    model_clear_frame();
  endtask

  function automatic logic [34:0] exp_rec(input int n);
    logic [PW-1:0] px;
    px = PW'(n);
    return {1'b1, px, d_bin[n], d_cnt[n], (d_cnt[n] >= CW'(MC)), (n == PN - 1)};
  endfunction

  task automatic send_hit(input logic [NB-1:0] a, input logic [CW-1:0] c, input bit done);
    model_hit(a, c);
    if (done) model_swap();
    hit_if.hit_vld  = 1'b1;
    hit_if.hit_addr = a;
    hit_if.hit_cnt  = c;
    hit_if.acq_done = done;
    @(posedge clk);
    #1;
    hit_if.hit_vld  = 1'b0;
    hit_if.acq_done = 1'b0;
  endtask

  task automatic pulse_done(input bit discard);
    if (discard) model_clear_frame();
    else         model_swap();
    hit_if.acq_done = 1'b1;
    @(posedge clk);
    #1;
    hit_if.acq_done = 1'b0;
  endtask

  task automatic send_frame(input int p, input int nh, input bit done_last);
    for (int k = 0; k < nh; k++) begin
      send_hit(NB'((k * (17 + 6 * p) + 29 * p + 3) % 256),
               CW'((k * (5 + 2 * p) + p) % 13),
               done_last && (k == nh - 1));
    end
  endtask

  // Accept stop_at records with pk_rdy high rdy_pct% of cycles. Returns at the
  // negedge of the last accepted record when stopping early, else re-aligned
  // to just after the following posedge.
  task automatic drain(input int rdy_pct, input int stop_at);
    int          n;
    bit          stalled;
    logic [34:0] cur;
    logic [34:0] prev;
    n       = 0;
    stalled = 1'b0;
    prev    = '0;
    rec_n   = 0;
    for (int cyc = 0; cyc < 8000 && n < stop_at; cyc++) begin
      pk_if.pk_rdy = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      cur = {pk_if.pk_vld, pk_if.pk_pixel, pk_if.pk_bin, pk_if.pk_cnt, pk_if.pk_hit, pk_if.pk_last};
      if (stalled) chk("hold", cur, prev);
      stalled = 1'b0;
      if (pk_if.pk_vld && pk_if.pk_rdy) begin
        chk("rec", cur, exp_rec(n));
        cap[n] = {pk_if.pk_bin, pk_if.pk_cnt, pk_if.pk_hit};
        n++;
        rec_n = n;
      end else if (pk_if.pk_vld) begin
        stalled = 1'b1;
        prev    = cur;
      end
      if (n < stop_at) begin
        @(posedge clk);
        #1;
      end
    end
    chk("drain_cnt", n, stop_at);
    if (stop_at == PN) begin
      @(posedge clk);
      #1;
      pk_if.pk_rdy = 1'b0;
    end
  endtask

  task automatic count_vld(input int ncyc, output int seen);
    seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (pk_if.pk_vld) seen++;
    end
  endtask

  initial begin
    int seen;
    hit_if.hit_vld  = 1'b0;
    hit_if.hit_addr = '0;
    hit_if.hit_cnt  = '0;
    hit_if.acq_done = 1'b0;
    pk_if.pk_rdy    = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", pk_if.pk_vld, 0);
    chk("rst_out", {pk_if.pk_pixel, pk_if.pk_bin, pk_if.pk_cnt, pk_if.pk_hit, pk_if.pk_last}, 0);
    chk("rst_ovf", ovf_err, 0);
    res = 1'b1;
    @(posedge clk);
    #1;

    // Directed: two hits per pixel; ties keep the earlier bin; (1,5) then (2,4)
    // back-to-back on one entry needs the just-written 5 to reject the 4.
    send_hit(8'd5, 16'd1, 1'b0);
    send_hit(8'd9, 16'd1, 1'b0);
    send_hit(8'd5, 16'd2, 1'b0);
    send_hit(8'd6, 16'd1, 1'b0);
    send_hit(8'd3, 16'd4, 1'b0);
    send_hit(8'd7, 16'd4, 1'b0);
    send_hit(8'd1, 16'd5, 1'b0);
    send_hit(8'd2, 16'd4, 1'b0);
    pulse_done(1'b0);
    chk("dir_lat1", pk_if.pk_vld, 0);
    drain(100, PN);
    chk("dir_p0", cap[0], {8'd5, 16'd1, 1'b0});
    chk("dir_p1", cap[1], {8'd5, 16'd2, 1'b0});
    chk("dir_p2_tie", cap[2], {8'd3, 16'd4, 1'b1});
    chk("dir_p3_byp", cap[3], {8'd1, 16'd5, 1'b1});
    chk("dir_p4_zero", cap[4], {8'd0, 16'd0, 1'b0});

    // Full frame with acq_done on the last hit: pk_vld exactly two cycles later.
    send_frame(1, PN * DN, 1'b1);
    chk("lat_t1", pk_if.pk_vld, 0);
    @(posedge clk);
    #1;
    chk("lat_t2", pk_if.pk_vld, 1);
    drain(100, PN);

    // Backpressure while the next frame accumulates in the other bank.
    send_frame(2, PN * DN, 1'b1);
    fork
      drain(30, PN);
      send_frame(3, PN * DN, 1'b0);
    join
    pulse_done(1'b0);
    drain(100, PN);

    // Overlap: a second acq_done mid-drain is discarded; the third frame is clean.
    send_frame(4, PN * DN, 1'b1);
    rec_n = 0;
    fork
      drain(100, PN);
      begin
        send_frame(5, 10, 1'b0);
        for (int c = 0; c < 2000 && rec_n < 50; c++) begin
          @(posedge clk);
          #1;
        end
        chk("ovl_reach50", (rec_n >= 50), 1);
        pulse_done(1'b1);
      end
    join
    chk("ovf_set", ovf_err, 1);
    count_vld(30, seen);
    chk("ovl_quiet", seen, 0);
    send_frame(6, 300, 1'b0);
    pulse_done(1'b0);
    drain(100, PN);
    chk("ovf_sticky", ovf_err, 1);

    // Reset mid-drain at record 100, with next-frame hits already accumulated.
    send_frame(7, PN * DN, 1'b1);
    rec_n = 0;
    fork
      drain(100, 100);
      send_frame(8, 20, 1'b0);
    join
    res = 1'b0;
    #1;
    chk("rstmid_vld", pk_if.pk_vld, 0);
    chk("rstmid_ovf", ovf_err, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    res = 1'b1;
    count_vld(10, seen);
    chk("rstmid_quiet", seen, 0);
    send_frame(9, 150, 1'b0);
    pulse_done(1'b0);
    drain(70, PN);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
